counter_sequencer: RTL

//   Controller that sequences a WIDTH-bit up-counter datapath: start/stop/pause commands,

---
 rtl/counter_seq_pkg.sv | 23 ++
 rtl/seq_prescaler.sv | 48 ++++
 rtl/counter_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/counter_seq_pkg.sv
// +-----------------------------------------------------------------------+
// | counter_seq_pkg : state encoding shared by the counter sequencer      |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

package counter_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HOLD = 2'd2,
      ST_DONE = 2'd3
   } seq_state_e;

   function automatic logic is_active(input seq_state_e s);
      return (s == ST_RUN) || (s == ST_HOLD);
   endfunction

endpackage

`default_nettype wire

// File: rtl/seq_prescaler.sv
// +-----------------------------------------------------------------------+
// | seq_prescaler : one-in-PRESCALE advance tick with clear and freeze    |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module seq_prescaler #(
   parameter int PRESCALE = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clr_i,
   input  logic hold_i,
   output logic tick_o,
   output logic tick_next_o
);

   localparam int            PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] pre_q;
   logic [PW-1:0] pre_d;

   always_comb begin
      pre_d = pre_q;
      if (clr_i) begin
         pre_d = '0;
      end else if (!hold_i) begin
         pre_d = (pre_q == LAST) ? '0 : pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_q <= '0;
      end else begin
         pre_q <= pre_d;
      end
   end

   // tick_next_o lets the parent register a pulse aligned with the advance cycle
   assign tick_o      = (pre_q == LAST);
   assign tick_next_o = (pre_d == LAST);

endmodule

`default_nettype wire

// File: rtl/counter_sequencer.sv
// +-----------------------------------------------------------------------+
// | counter_sequencer : start/stop/pause sequencer for a WIDTH-bit        |
// | up-counter; optional prescaler under COUNT_SEQ_PRESCALE_EN. Rev 1.0   |
// +-----------------------------------------------------------------------+
`timescale 1ns/1ps
`default_nettype none

module counter_sequencer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             stop,
   input  logic             pause,
   input  logic             auto_reload,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             tc_pulse,
   output logic             done
);

   import counter_seq_pkg::*;

   seq_state_e       state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] term_q,  term_d;
   logic             busy_q, done_q, tc_q;
   logic             w_tick;
   logic             w_tick_next;
   logic             w_tc_d;

`ifdef COUNT_SEQ_PRESCALE_EN
   logic w_pre_clr;
   logic w_pre_hold;

   assign w_pre_clr  = start | stop;
   assign w_pre_hold = (state_q != ST_RUN) | pause;

   seq_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk         (clk),
      .reset       (reset),
      .clr_i       (w_pre_clr),
      .hold_i      (w_pre_hold),
      .tick_o      (w_tick),
      .tick_next_o (w_tick_next)
   );
`else
   logic w_unused_prescale;

   assign w_unused_prescale = (PRESCALE > 0);
   assign w_tick            = 1'b1;
   assign w_tick_next       = 1'b1;
`endif

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      term_d  = term_q;
      if (stop) begin
         state_d = ST_IDLE;
         count_d = '0;
      end else if (start) begin
         state_d = ST_RUN;
         term_d  = load_val;
         count_d = '0;
      end else begin
         case (state_q)
            ST_RUN: begin
               if (pause) begin
                  state_d = ST_HOLD;
               end else if (w_tick) begin
                  if (count_q == term_q) begin
                     count_d = '0;
                     if (!auto_reload) begin
                        state_d = ST_DONE;
                     end
                  end else begin
                     count_d = count_q + 1'b1;
                  end
               end
            end
            ST_HOLD: begin
               if (!pause) begin
                  state_d = ST_RUN;
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   // Pulse is registered one edge early so it is visible during the cycle whose edge performs the terminal advance
   assign w_tc_d = (state_d == ST_RUN) && (count_d == term_d) && w_tick_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         term_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         term_q  <= term_d;
         busy_q  <= is_active(state_d);
         done_q  <= (state_d == ST_DONE);
         tc_q    <= w_tc_d;
      end
   end

   assign count    = count_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign tc_pulse = tc_q;

endmodule

`default_nettype wire
